mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RV32I memory block between two requesters: the instruction-fetch port (I) and the load/store data port (D).
- The memory has a registered read with 1-cycle latency, and its funct3 input is shared by the read and write paths. The arbiter therefore grants at most one access per cycle.
- It drives the memory's address, data and funct3 inputs, routes the read data back, and tags responses to the correct requester.
- It sits between the core's fetch/LSU stages and the memory.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin on conflict; 1 = fixed priority with D winning.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  32  fetch byte address; word aligned; stable while i_req
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  rdata holds the fetch word this cycle
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  RV32I funct3 of the load/store
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; byte/half data in the low bits
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  rdata holds load data this cycle
- rdata  out  32  shared response data; equals mem_read_data
- mem_write_mem  out  1  to memory write_mem
- mem_funct3  out  3  to memory funct3
- mem_write_address  out  32  to memory write_address
- mem_write_data  out  32  to memory write_data
- mem_read_address  out  32  to memory read_address
- mem_read_data  in  32  from memory read_data
- conflict_count  out  CNT_W  cycles in which both requests were asserted (saturating)

Behaviour:
- Reset: rst is asynchronous and active-high. It clears the following:
  - i_rvalid, d_rvalid and the response tag register;
  - conflict_count;
  - the round-robin pointer, which resets to favour D.
- Idle (no grant) memory drive:
  - mem_write_mem = 0, mem_funct3 = 3'b010;
  - mem_read_address = 0, mem_write_address = 0, mem_write_data = 0.
- Grant logic (combinational):
  - Only i_req: i_gnt = 1.
  - Only d_req: d_gnt = 1.
  - Both asserted, ARB_MODE = 1: D wins.
  - Both asserted, ARB_MODE = 0: the pointer holder wins; the pointer flips to the loser on the clock edge after the conflict grant.
  - Never i_gnt & d_gnt in the same cycle.
  - Grants are suppressed while rst = 1.
- I granted:
  - mem_read_address = i_addr, mem_funct3 = 3'b010, mem_write_mem = 0.
  - i_rvalid = 1 exactly one cycle later; rdata = mem_read_data.
- D granted, load (d_we = 0):
  - mem_read_address = d_addr, mem_funct3 = d_funct3.
  - d_rvalid = 1 one cycle later; the memory applies sign/zero extension.
- D granted, store (d_we = 1):
  - mem_write_mem = 1, mem_write_address = d_addr, mem_write_data = d_wdata, mem_funct3 = d_funct3.
  - Posted: the write commits on the grant edge; no d_rvalid is produced.
- Pipelining:
  - One access is issued per cycle, back to back; throughput is 1 grant per cycle.
  - A response for a grant at cycle N and a new grant at cycle N+1 coexist.
- Response tag: registered, 1 bit plus valid.
  - i_rvalid and d_rvalid are mutually exclusive.
  - Neither is asserted the cycle after a store or an idle cycle.
- Requesters must accept responses unconditionally; there is no response back-pressure.
- Load-after-store: a store to address A at cycle N followed by a load of A at cycle N+1 returns the new data, since the write lands at the N edge.
- conflict_count increments on every cycle with i_req & d_req & !rst. It saturates at all-ones with no wrap.
- Reset mid-operation:
  - A read granted in the cycle rst rises produces no rvalid.
  - A store whose grant edge coincides with rst assertion is not issued, because grants are gated.

Test Plan:
- Fetch-only stream: i_req held with i_addr = 0, 4, 8 -> i_gnt = 1 every cycle; i_rvalid one cycle after each grant with rdata = preloaded words 0x00000013, 0x00100093, 0x00200113.
- Conflict, ARB_MODE = 0: both requesting continuously, d_we = 0 -> grants alternate D, I, D, I; conflict_count = 4 after 4 cycles; never both gnt.
- Conflict, ARB_MODE = 1: both requesting for 3 cycles -> d_gnt for all 3, i_gnt = 0; after d_req drops, i_gnt = 1 the next cycle.
- Store byte then load: store funct3 = 000, d_addr = 0x101, d_wdata = 0xFFFFFF80; next cycle load funct3 = 000 at 0x101 -> d_rvalid with rdata = 0xFFFFFF80. Repeating the load with funct3 = 100 -> rdata = 0x00000080; no d_rvalid for the store.
- Reset mid-read: grant a fetch and assert rst in the same cycle -> no i_rvalid next cycle, conflict_count = 0, outputs at idle values.
- Saturation with CNT_W = 4: 20 conflict cycles -> conflict_count = 15 and held.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered-read memory between fetch (I) and load/store (D) ports.
module mem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_funct3,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      rdata,
  output logic             mem_write_mem,
  output logic [2:0]       mem_funct3,
  output logic [31:0]      mem_write_address,
  output logic [31:0]      mem_write_data,
  output logic [31:0]      mem_read_address,
  input  logic [31:0]      mem_read_data,
  output logic [CNT_W-1:0] conflict_count
);
  logic             r_ptr, r_vld, r_tag;
  logic [CNT_W-1:0] r_cnt;
  logic             w_both, w_d_win, w_d_rd, w_d_wr;
  always_comb begin
    w_both            = i_req & d_req;
    w_d_win           = (ARB_MODE == 1) ? 1'b1 : r_ptr;
    d_gnt             = !rst & d_req & (!i_req | w_d_win);
    i_gnt             = !rst & i_req & (!d_req | !w_d_win);
    w_d_rd            = d_gnt & !d_we;
    w_d_wr            = d_gnt & d_we;
    mem_write_mem     = w_d_wr;
    mem_funct3        = d_gnt ? d_funct3 : 3'b010;
    mem_read_address  = i_gnt ? i_addr : w_d_rd ? d_addr : 32'd0;
    mem_write_address = w_d_wr ? d_addr : 32'd0;
    mem_write_data    = w_d_wr ? d_wdata : 32'd0;
  end
  // r_ptr = 1 favours D; stores are posted so they never set the response valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b1;
      r_vld <= 1'b0;
      r_tag <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_vld <= i_gnt | w_d_rd;
      r_tag <= d_gnt;
      if (w_both) begin
        r_ptr <= !r_ptr;
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign i_rvalid       = r_vld & !r_tag;
  assign d_rvalid       = r_vld & r_tag;
  assign rdata          = mem_read_data;
  assign conflict_count = r_cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grants, responses and conflict counting with a memory model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [2:0] d_funct3 = 3'b010;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_write_mem;
  logic [2:0] mem_funct3;
  logic [31:0] rdata, mem_write_address, mem_write_data, mem_read_address, mem_read_data;
  logic [15:0] cc0;
  mem_arbiter #(.ARB_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata), .mem_write_mem(mem_write_mem),
    .mem_funct3(mem_funct3), .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data), .conflict_count(cc0));

  logic i_gnt1, i_rv1, d_gnt1, d_rv1, wm1;
  logic [2:0] f31;
  logic [31:0] rd1, wa1, wd1, ra1;
  logic [15:0] cc1;
  mem_arbiter #(.ARB_MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rv1),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rv1), .rdata(rd1), .mem_write_mem(wm1),
    .mem_funct3(f31), .mem_write_address(wa1), .mem_write_data(wd1),
    .mem_read_address(ra1), .mem_read_data(32'd0), .conflict_count(cc1));

  logic i_gnt2, i_rv2, d_gnt2, d_rv2, wm2;
  logic [2:0] f32;
  logic [31:0] rd2, wa2, wd2, ra2;
  logic [3:0] cc2;
  mem_arbiter #(.ARB_MODE(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt2), .i_rvalid(i_rv2),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rv2), .rdata(rd2), .mem_write_mem(wm2),
    .mem_funct3(f32), .mem_write_address(wa2), .mem_write_data(wd2),
    .mem_read_address(ra2), .mem_read_data(32'd0), .conflict_count(cc2));

  // Memory model: 1-cycle registered read with RV32I extension, write lands on the grant edge
  logic [7:0] mem [0:1023];
  function automatic logic [31:0] mrd(input logic [31:0] a, input logic [2:0] f);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[9:0]]; b1 = mem[a[9:0] + 10'd1]; b2 = mem[a[9:0] + 10'd2]; b3 = mem[a[9:0] + 10'd3];
    case (f)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction
  always @(posedge clk) begin
    if (preload) begin
      {mem[3], mem[2], mem[1], mem[0]}   <= 32'h00000013;
      {mem[7], mem[6], mem[5], mem[4]}   <= 32'h00100093;
      {mem[11], mem[10], mem[9], mem[8]} <= 32'h00200113;
    end else if (mem_write_mem) begin
      mem[mem_write_address[9:0]] <= mem_write_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_write_address[9:0] + 10'd1] <= mem_write_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_write_address[9:0] + 10'd2] <= mem_write_data[23:16];
        mem[mem_write_address[9:0] + 10'd3] <= mem_write_data[31:24];
      end
    end
    mem_read_data <= mrd(mem_read_address, mem_funct3);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask

  logic [31:0] fetch_exp [0:2];
  logic dexp;
  initial begin
    fetch_exp[0] = 32'h00000013; fetch_exp[1] = 32'h00100093; fetch_exp[2] = 32'h00200113;
    step; step;
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_cc", cc0, 0);
    chk("rst_funct3", mem_funct3, 3'b010);
    chk("rst_wm", mem_write_mem, 0);
    i_req = 1; #1;
    chk("rst_gate_i_gnt", i_gnt, 0);
    rst = 0; preload = 0; i_req = 0;
    step;
    // Fetch-only stream
    for (int k = 0; k < 3; k++) begin
      i_req = 1; i_addr = 32'(4 * k); #1;
      chk("fetch_gnt", i_gnt, 1);
      chk("fetch_raddr", mem_read_address, 32'(4 * k));
      step;
      chk("fetch_rvalid", i_rvalid, 1);
      chk("fetch_d_rvalid", d_rvalid, 0);
      chk("fetch_rdata", rdata, fetch_exp[k]);
    end
    i_req = 0; step;
    chk("fetch_end_rvalid", i_rvalid, 0);
    // Conflict: round-robin on dut0, D-priority on dut1
    rst = 1; step; rst = 0;
    i_req = 1; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'd8; i_addr = 32'd0;
    for (int c = 0; c < 4; c++) begin
      dexp = (c % 2 == 0); #1;
      chk("rr_d_gnt", d_gnt, dexp);
      chk("rr_i_gnt", i_gnt, !dexp);
      chk("fp_d_gnt", d_gnt1, 1);
      chk("fp_i_gnt", i_gnt1, 0);
      step;
      chk("rr_d_rvalid", d_rvalid, dexp);
      chk("rr_i_rvalid", i_rvalid, !dexp);
      chk("rr_rdata", rdata, dexp ? 32'h00200113 : 32'h00000013);
    end
    chk("rr_cc", cc0, 4);
    chk("fp_cc", cc1, 4);
    d_req = 0; #1;
    chk("fp_i_after", i_gnt1, 1);
    chk("rr_i_after", i_gnt, 1);
    i_req = 0; step;
    // Store byte, then load it back signed and unsigned
    d_req = 1; d_we = 1; d_funct3 = 3'b000; d_addr = 32'h101; d_wdata = 32'hFFFFFF80; #1;
    chk("st_gnt", d_gnt, 1);
    chk("st_wm", mem_write_mem, 1);
    chk("st_waddr", mem_write_address, 32'h101);
    chk("st_wdata", mem_write_data, 32'hFFFFFF80);
    chk("st_funct3", mem_funct3, 3'b000);
    step;
    chk("st_no_rvalid", d_rvalid, 0);
    d_we = 0; #1;
    chk("ld_raddr", mem_read_address, 32'h101);
    chk("ld_wm", mem_write_mem, 0);
    step;
    chk("ld_rvalid", d_rvalid, 1);
    chk("ld_lb", rdata, 32'hFFFFFF80);
    d_funct3 = 3'b100; step;
    chk("ld_lbu", rdata, 32'h00000080);
    d_req = 0; step;
    chk("idle_rvalid", d_rvalid, 0);
    chk("idle_funct3", mem_funct3, 3'b010);
    chk("idle_raddr", mem_read_address, 0);
    chk("idle_waddr", mem_write_address, 0);
    chk("idle_wdata", mem_write_data, 0);
    // Reset asserted in the cycle of a fetch grant
    i_req = 1; i_addr = 32'd4; rst = 1; #1;
    chk("rstmid_gnt", i_gnt, 0);
    chk("rstmid_raddr", mem_read_address, 0);
    step;
    chk("rstmid_rvalid", i_rvalid, 0);
    chk("rstmid_cc", cc0, 0);
    chk("rstmid_funct3", mem_funct3, 3'b010);
    rst = 0; i_req = 0; step;
    // Saturation on the 4-bit counter
    i_req = 1; d_req = 1;
    for (int c = 0; c < 20; c++) begin
      #1 chk("sat_excl", {31'd0, i_gnt & d_gnt}, 0);
      step;
    end
    chk("sat_cc", cc2, 15);
    chk("sat_cc0", cc0, 20);
    step; step;
    chk("sat_hold", cc2, 15);
    i_req = 0; d_req = 0; step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
